// File: rtl/sub_128bit_iter.sv
// Iterative 128-bit subtractor (diff = a - b - bin), CHUNK_W bits per cycle, LSB chunk first.
// Optional registered zero flag on output port `zero` when SUB128_ZERO_FLAG_EN is defined.
module sub_128bit_iter #(
    parameter int unsigned CHUNK_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] a,
    input  logic [127:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] diff,
    output logic         bout
`ifdef SUB128_ZERO_FLAG_EN
    ,
    output logic         zero
`endif
);

    localparam int unsigned CW_SAFE = (CHUNK_W == 0) ? 1 : CHUNK_W;
    localparam int unsigned N       = 128 / CW_SAFE;
    localparam int unsigned CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW      = CW_SAFE + 1;

    // A power of two no larger than 128 always divides 128 evenly.
    if (CHUNK_W == 0 || CHUNK_W > 128 || (CHUNK_W & (CHUNK_W - 1)) != 0) begin : g_bad_chunk
        $error("sub_128bit_iter: CHUNK_W must be a power of two in 1..128");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       a_q, a_d;
    logic [127:0]       b_q, b_d;
    logic [127:0]       diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
`ifdef SUB128_ZERO_FLAG_EN
    logic               zero_q, zero_d;
`endif

    logic [CW_SAFE-1:0] a_k, b_k;
    logic [SW-1:0]      sub_k;

    always_comb begin
        a_k = '0;
        b_k = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_k = a_q[k*CW_SAFE +: CW_SAFE];
                b_k = b_q[k*CW_SAFE +: CW_SAFE];
            end
        end
        // MSB of the widened difference is the chunk borrow-out.
        sub_k = {1'b0, a_k} - {1'b0, b_k} - SW'(borrow_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        bout_d    = bout_q;
`ifdef SUB128_ZERO_FLAG_EN
        zero_d    = zero_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
`ifdef SUB128_ZERO_FLAG_EN
                    zero_d   = 1'b1;
`endif
                    state_d  = CALC;
                end
            end
            CALC: begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        diff_d[k*CW_SAFE +: CW_SAFE] = sub_k[CW_SAFE-1:0];
                    end
                end
                borrow_d = sub_k[CW_SAFE];
`ifdef SUB128_ZERO_FLAG_EN
                zero_d   = zero_q & (sub_k[CW_SAFE-1:0] == '0);
`endif
                if (cnt_q == CNT_W'(N - 1)) begin
                    bout_d  = sub_k[CW_SAFE];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
`ifdef SUB128_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
`ifdef SUB128_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SUB128_ZERO_FLAG_EN
    assign zero = zero_q;
`endif

endmodule
